// File: rtl/ir_beacon_pkg.sv
// Shared types for the IR beacon classifier: class encodings, debounce FSM
// states and the confirm/drop counter width helper.
package ir_beacon_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_LO   = 2'b01,
        CLS_HI   = 2'b10
    } cls_e;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    function automatic int cnt_width(input int confirm_n, input int drop_n);
        int m;
        m = (confirm_n > drop_n) ? confirm_n : drop_n;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ir_sample_classify.sv
// Window timer, capture of the upstream edge count once per window and band
// classification of the captured value.
module ir_sample_classify
    import ir_beacon_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned SAMPLE_OFFSET = 50000000,
    parameter int unsigned LO_MIN        = 80,
    parameter int unsigned LO_MAX        = 120,
    parameter int unsigned HI_MIN        = 400,
    parameter int unsigned HI_MAX        = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] b_in,
    output cls_e       sample_cls,
    output logic       sample_vld
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    // Down-counter value v corresponds to window phase WINDOW_CYCLES-1-v.
    localparam logic [WIN_W-1:0] CAP_AT   = WIN_W'(WINDOW_CYCLES - 1 - SAMPLE_OFFSET);
    localparam logic [9:0] LO_MIN_V = 10'(LO_MIN);
    localparam logic [9:0] LO_MAX_V = 10'(LO_MAX);
    localparam logic [9:0] HI_MIN_V = 10'(HI_MIN);
    localparam logic [9:0] HI_MAX_V = 10'(HI_MAX);

    logic [WIN_W-1:0] win_q, win_d;
    logic [9:0]       cap_q, cap_d;
    logic             vld_q, vld_d;

    always_comb begin
        win_d = (win_q == '0) ? WIN_LAST : win_q - 1'b1;
        vld_d = (win_q == CAP_AT);
        cap_d = vld_d ? b_in : cap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= WIN_LAST;
            cap_q <= '0;
            vld_q <= 1'b0;
        end else begin
            win_q <= win_d;
            cap_q <= cap_d;
            vld_q <= vld_d;
        end
    end

    // All-ones means the upstream counter overflowed, never a valid beacon.
    always_comb begin
        sample_cls = CLS_NONE;
        if (cap_q != 10'h3FF) begin
            if (cap_q >= LO_MIN_V && cap_q <= LO_MAX_V) begin
                sample_cls = CLS_LO;
            end else if (cap_q >= HI_MIN_V && cap_q <= HI_MAX_V) begin
                sample_cls = CLS_HI;
            end
        end
    end

    assign sample_vld = vld_q;

endmodule

// File: rtl/ir_beacon_classifier.sv
// IR beacon classifier: samples the edge count once per window and debounces
// the band class with confirm/drop counting.
//   state   | meaning
//   SEARCH  | no beacon, waiting for a non-NONE sample
//   CONFIRM | candidate seen, counting consecutive matches
//   LOCKED  | beacon class published
//   HOLD    | locked but recent samples disagree, counting misses
module ir_beacon_classifier
    import ir_beacon_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned SAMPLE_OFFSET = 50000000,
    parameter int unsigned LO_MIN        = 80,
    parameter int unsigned LO_MAX        = 120,
    parameter int unsigned HI_MIN        = 400,
    parameter int unsigned HI_MAX        = 600,
    parameter int unsigned CONFIRM_N     = 3,
    parameter int unsigned DROP_N        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] b_in,
    output logic [1:0] beacon_class,
    output logic       beacon_valid,
    output logic       class_change,
    output logic       sample_strobe
);

    localparam int CNT_W = cnt_width(int'(CONFIRM_N), int'(DROP_N));
    localparam logic [CNT_W-1:0] CONFIRM_V = CNT_W'(CONFIRM_N);
    localparam logic [CNT_W-1:0] DROP_V    = CNT_W'(DROP_N);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

    if (LO_MAX >= HI_MIN) begin : g_bad_bands
        $error("ir_beacon_classifier: LO_MAX must be below HI_MIN");
    end
    if (SAMPLE_OFFSET >= WINDOW_CYCLES) begin : g_bad_offset
        $error("ir_beacon_classifier: SAMPLE_OFFSET must be below WINDOW_CYCLES");
    end
    if (CONFIRM_N < 1 || DROP_N < 1) begin : g_bad_counts
        $error("ir_beacon_classifier: CONFIRM_N and DROP_N must be at least 1");
    end

    cls_e sample_cls;
    logic sample_vld;

    ir_sample_classify #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .SAMPLE_OFFSET (SAMPLE_OFFSET),
        .LO_MIN        (LO_MIN),
        .LO_MAX        (LO_MAX),
        .HI_MIN        (HI_MIN),
        .HI_MAX        (HI_MAX)
    ) u_sample (
        .clk        (clk),
        .rst_n      (reset),
        .b_in       (b_in),
        .sample_cls (sample_cls),
        .sample_vld (sample_vld)
    );

    state_e           state_q, state_d;
    cls_e             cand_q, cand_d;
    cls_e             out_q, out_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] match_inc, miss_inc;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        out_d     = out_q;
        match_d   = match_q;
        miss_d    = miss_q;
        match_inc = (match_q == '1) ? match_q : match_q + ONE_V;
        miss_inc  = (miss_q == '1) ? miss_q : miss_q + ONE_V;

        if (sample_vld) begin
            case (state_q)
                ST_SEARCH: begin
                    if (sample_cls != CLS_NONE) begin
                        cand_d  = sample_cls;
                        match_d = ONE_V;
                        if (CONFIRM_N == 1) begin
                            state_d = ST_LOCKED;
                            out_d   = sample_cls;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (sample_cls == CLS_NONE) begin
                        state_d = ST_SEARCH;
                        cand_d  = CLS_NONE;
                        match_d = '0;
                    end else if (sample_cls == cand_q) begin
                        match_d = match_inc;
                        if (match_inc >= CONFIRM_V) begin
                            state_d = ST_LOCKED;
                            out_d   = cand_q;
                        end
                    end else begin
                        cand_d  = sample_cls;
                        match_d = ONE_V;
                    end
                end
                ST_LOCKED: begin
                    if (sample_cls != out_q) begin
                        miss_d = ONE_V;
                        if (DROP_N == 1) begin
                            state_d = ST_SEARCH;
                            out_d   = CLS_NONE;
                            cand_d  = CLS_NONE;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sample_cls == out_q) begin
                        miss_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc >= DROP_V) begin
                            state_d = ST_SEARCH;
                            out_d   = CLS_NONE;
                            cand_d  = CLS_NONE;
                            match_d = '0;
                            miss_d  = '0;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        chg_d = (out_d != out_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SEARCH;
            cand_q  <= CLS_NONE;
            out_q   <= CLS_NONE;
            match_q <= '0;
            miss_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            out_q   <= out_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            chg_q   <= chg_d;
        end
    end

    assign beacon_class  = out_q;
    assign beacon_valid  = (out_q != CLS_NONE);
    assign class_change  = chg_q;
    assign sample_strobe = sample_vld;

endmodule

// File: tb/tb_ir_beacon_classifier.sv
// Self-checking bench for ir_beacon_classifier against a history-based
// reference model of the confirm/drop rules.
module tb_ir_beacon_classifier;

    localparam int W   = 20;
    localparam int OFF = 10;
    localparam int CN  = 3;
    localparam int DN  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] b_in;
    logic [1:0] beacon_class;
    logic       beacon_valid;
    logic       class_change;
    logic       sample_strobe;

    int errors = 0;
    int checks = 0;

    logic [1:0] m_out;
    int         hist[$];

    always #5 clk = ~clk;

    ir_beacon_classifier #(
        .WINDOW_CYCLES (W),
        .SAMPLE_OFFSET (OFF),
        .LO_MIN        (80),
        .LO_MAX        (120),
        .HI_MIN        (400),
        .HI_MAX        (600),
        .CONFIRM_N     (CN),
        .DROP_N        (DN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .b_in          (b_in),
        .beacon_class  (beacon_class),
        .beacon_valid  (beacon_valid),
        .class_change  (class_change),
        .sample_strobe (sample_strobe)
    );

    function automatic int ref_cls(input int v);
        if (v >= 80 && v <= 120) return 1;
        if (v >= 400 && v <= 600) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_out = 2'd0;
        hist.delete();
    endtask

    // Output locks after CN identical non-NONE samples in a row, and drops
    // after DN samples in a row that differ from it; history restarts on change.
    task automatic model_sample(input int c);
        bit all;
        hist.push_back(c);
        all = 1'b1;
        if (m_out == 2'd0) begin
            if (c == 0 || hist.size() < CN) all = 1'b0;
            else for (int k = 0; k < CN; k++) if (hist[hist.size()-1-k] != c) all = 1'b0;
            if (all) begin
                m_out = 2'(c);
                hist.delete();
            end
        end else begin
            if (hist.size() < DN) all = 1'b0;
            else for (int k = 0; k < DN; k++) if (hist[hist.size()-1-k] == int'(m_out)) all = 1'b0;
            if (all) begin
                m_out = 2'd0;
                hist.delete();
            end
        end
    endtask

    task automatic run_window(input int val, input string tag);
        logic [1:0] prev;
        bit got;
        b_in = 10'(val);
        prev = m_out;
        model_sample(ref_cls(val));
        got = 1'b0;
        for (int i = 0; i < 2*W + 2 && !got; i++) begin
            @(negedge clk);
            if (sample_strobe) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s strobe_timeout: no sample_strobe within %0d cycles", tag, 2*W+2);
            return;
        end
        @(negedge clk);
        checks++;
        if (beacon_class !== m_out) begin
            errors++;
            $display("FAIL %s class (b_in=%0d): got %0d expected %0d", tag, val, beacon_class, m_out);
        end
        checks++;
        if (beacon_valid !== (m_out != 2'd0)) begin
            errors++;
            $display("FAIL %s valid (b_in=%0d): got %0b expected %0b", tag, val, beacon_valid, m_out != 2'd0);
        end
        checks++;
        if (class_change !== (m_out != prev)) begin
            errors++;
            $display("FAIL %s change (b_in=%0d): got %0b expected %0b", tag, val, class_change, m_out != prev);
        end
        checks++;
        if (sample_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s strobe_width: got %0b expected 0", tag, sample_strobe);
        end
        @(negedge clk);
        checks++;
        if (class_change !== 1'b0) begin
            errors++;
            $display("FAIL %s change_width: got %0b expected 0", tag, class_change);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (beacon_class !== 2'd0 || beacon_valid !== 1'b0 || class_change !== 1'b0 || sample_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: got class=%0d valid=%0b change=%0b strobe=%0b expected all 0",
                     tag, beacon_class, beacon_valid, class_change, sample_strobe);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        b_in  = 10'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_hold");
        reset = 1'b1;
        n = 0;
        for (int i = 1; i <= 2*W && n == 0; i++) begin
            @(negedge clk);
            if (sample_strobe) n = i;
        end
        checks++;
        if (n != OFF + 1) begin
            errors++;
            $display("FAIL reset first_strobe: got cycle %0d expected cycle %0d", n, OFF + 1);
        end
        model_sample(0);
        @(negedge clk);
        checks++;
        if (beacon_class !== 2'd0 || class_change !== 1'b0) begin
            errors++;
            $display("FAIL reset first_sample: got class=%0d change=%0b expected 0 0", beacon_class, class_change);
        end
        @(negedge clk);
    endtask

    task automatic test_lock_lo();
        run_window(100, "lock_lo1");
        run_window(100, "lock_lo2");
        checks++;
        if (beacon_class !== 2'b00) begin
            errors++;
            $display("FAIL lock_lo early: got %0d expected 0", beacon_class);
        end
        run_window(100, "lock_lo3");
        checks++;
        if (beacon_class !== 2'b01 || beacon_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_lo locked: got class=%0d valid=%0b expected 1 1", beacon_class, beacon_valid);
        end
    endtask

    task automatic test_hold_drop();
        run_window(0, "hold_miss1");
        run_window(100, "hold_recover");
        run_window(0, "drop_miss1");
        run_window(0, "drop_miss2");
        checks++;
        if (beacon_class !== 2'b00 || beacon_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop final: got class=%0d valid=%0b expected 0 0", beacon_class, beacon_valid);
        end
    endtask

    task automatic test_candidate_switch();
        run_window(100, "cand_lo");
        run_window(500, "cand_hi1");
        run_window(500, "cand_hi2");
        run_window(500, "cand_hi3");
        checks++;
        if (beacon_class !== 2'b10) begin
            errors++;
            $display("FAIL cand locked_hi: got %0d expected 2", beacon_class);
        end
    endtask

    task automatic test_boundaries();
        run_window(0, "bnd_clear1");
        run_window(0, "bnd_clear2");
        run_window(120, "bnd_120a");
        run_window(120, "bnd_120b");
        run_window(120, "bnd_120c");
        run_window(80, "bnd_80a");
        run_window(80, "bnd_80b");
        run_window(121, "bnd_121");
        run_window(79, "bnd_79");
        run_window(601, "bnd_601");
        run_window(1023, "bnd_1023");
        run_window(400, "bnd_400a");
        run_window(400, "bnd_400b");
        run_window(400, "bnd_400c");
        run_window(600, "bnd_600");
        run_window(1023, "bnd_1023b");
        run_window(601, "bnd_601b");
    endtask

    task automatic test_reset_mid();
        run_window(100, "mid_conf1");
        run_window(100, "mid_conf2");
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_outputs_zero("mid_confirm_reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_window(100, "mid_fresh1");
        run_window(100, "mid_fresh2");
        run_window(100, "mid_fresh3");
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_outputs_zero("mid_locked_reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_window(100, "mid_after1");
    endtask

    task automatic test_random();
        int v, last;
        last = 100;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(9, 0))
                0: v = int'($urandom_range(120, 80));
                1: v = int'($urandom_range(600, 400));
                2: v = int'($urandom_range(79, 0));
                3: v = int'($urandom_range(1023, 601));
                4: v = int'($urandom_range(399, 121));
                default: v = last;
            endcase
            last = v;
            run_window(v, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lock_lo();
        test_hold_drop();
        test_candidate_switch();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
